// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_WORD_WIDTH = 32;

  // Which port owns an outstanding read, and which port was granted last.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0] = fetch, req[1] = data.
// The last-grant flag changes only when a grant is issued.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e last_q;

  // Single requester wins outright; on a tie the port not granted last wins.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[0] && (!req[1] || last_q == OWN_D)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  // Remember the most recent winner; reset favours fetch on the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWN_D;
    end else if (gnt[0]) begin
      last_q <= OWN_IF;
    end else if (gnt[1]) begin
      last_q <= OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch read port and a data read/write port onto a
// single-port synchronous memory with one-cycle read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  logic       arb_en_q;
  logic       pend_q;
  owner_e     own_q;
  logic [1:0] gnt;
  logic       rd_gnt;

  // Grants are held off while reset is asserted and for the first cycle after
  // release, so a request present at release is not accepted early.
  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n & arb_en_q),
    .req   ({d_req, if_req}),
    .gnt   (gnt)
  );

  assign if_gnt = gnt[0];
  assign d_gnt  = gnt[1];
  assign rd_gnt = gnt[0] | (gnt[1] & ~d_we);

  // Steer the granted port onto the memory; no grant means no access.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = d_wdata;
    if (gnt[1]) begin
      mem_addr  = d_addr;
      mem_write = d_we;
      mem_read  = ~d_we;
    end else if (gnt[0]) begin
      mem_read  = 1'b1;
    end
  end

  // Track the outstanding read and its owner; reset discards it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arb_en_q <= 1'b0;
      pend_q   <= 1'b0;
      own_q    <= OWN_IF;
    end else begin
      arb_en_q <= 1'b1;
      pend_q   <= rd_gnt;
      if (rd_gnt) begin
        own_q <= gnt[1] ? OWN_D : OWN_IF;
      end
    end
  end

  // Response valid is also masked by rst_n so an asserted reset hides it at once.
  assign if_rvalid = rst_n & pend_q & (own_q == OWN_IF);
  assign d_rvalid  = rst_n & pend_q & (own_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks for mem_arbiter against a behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:255] = '{default: '0};
  logic [31:0] sh  [0:255] = '{default: '0};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory with one-cycle read latency and a backdoor.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, ".mem_read"},  32'(mem_read),  32'd0);
    chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
  endtask

  initial begin
    logic        last_d, exp_pend, exp_own_d, gi, gd, gi_prev, gd_prev;
    logic [31:0] exp_data;

    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = '0;
    bd_we = 1'b1; bd_addr = 8'h10; bd_data = 32'hCAFE0001;
    sh[8'h10] = 32'hCAFE0001;
    tick();
    bd_we = 1'b0;
    #4 chk_all_zero("rst_a");
    tick();
    #4 chk_all_zero("rst_b");
    tick();

    // Release with both requests pending: nothing granted this cycle.
    rst_n = 1'b1;
    #4 chk_all_zero("rel");
    tick();

    // Single fetch read.
    d_req = 1'b0;
    #4;
    chk("f1.if_gnt", 32'(if_gnt), 32'd1);
    chk("f1.d_gnt", 32'(d_gnt), 32'd0);
    chk("f1.mem_read", 32'(mem_read), 32'd1);
    chk("f1.mem_write", 32'(mem_write), 32'd0);
    chk("f1.mem_addr", mem_addr, 32'h10);
    tick();

    // Data write to 0x20, while the fetch response returns.
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    #4;
    chk("f1.if_rvalid", 32'(if_rvalid), 32'd1);
    chk("f1.if_rdata", if_rdata, 32'hCAFE0001);
    chk("f1.d_rvalid", 32'(d_rvalid), 32'd0);
    chk("w.d_gnt", 32'(d_gnt), 32'd1);
    chk("w.mem_write", 32'(mem_write), 32'd1);
    chk("w.mem_read", 32'(mem_read), 32'd0);
    chk("w.mem_addr", mem_addr, 32'h20);
    chk("w.mem_wdata", mem_wdata, 32'h12345678);
    tick();
    sh[8'h20] = 32'h12345678;

    // Read back the same address.
    d_we = 1'b0;
    #4;
    chk("r.d_gnt", 32'(d_gnt), 32'd1);
    chk("r.mem_read", 32'(mem_read), 32'd1);
    chk("r.mem_write", 32'(mem_write), 32'd0);
    chk("w.no_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("w.no_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    d_req = 1'b0;
    #4;
    chk("r.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("r.d_rdata", d_rdata, 32'h12345678);
    chk("r.if_rvalid", 32'(if_rvalid), 32'd0);
    tick();

    // Both held for 6 cycles: IF,D,IF,D,IF,D (last grant was D).
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #4;
      chk($sformatf("alt%0d.if_gnt", i), 32'(if_gnt), 32'((i % 2) == 0));
      chk($sformatf("alt%0d.d_gnt", i), 32'(d_gnt), 32'((i % 2) == 1));
      if (i > 0) begin
        chk($sformatf("alt%0d.if_rvalid", i), 32'(if_rvalid), 32'(((i - 1) % 2) == 0));
        chk($sformatf("alt%0d.d_rvalid", i), 32'(d_rvalid), 32'(((i - 1) % 2) == 1));
        chk($sformatf("alt%0d.rdata", i), ((i - 1) % 2 == 0) ? if_rdata : d_rdata,
            ((i - 1) % 2 == 0) ? 32'hCAFE0001 : 32'h12345678);
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    #4;
    chk("alt6.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("alt6.if_rvalid", 32'(if_rvalid), 32'd0);
    chk("alt6.d_rdata", d_rdata, 32'h12345678);
    tick();

    // Data alone four times, then a tie goes to fetch.
    d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("donly%0d.d_gnt", i), 32'(d_gnt), 32'd1);
      chk($sformatf("donly%0d.if_gnt", i), 32'(if_gnt), 32'd0);
      tick();
    end
    if_req = 1'b1;
    #4;
    chk("tie.if_gnt", 32'(if_gnt), 32'd1);
    chk("tie.d_gnt", 32'(d_gnt), 32'd0);
    chk("tie.d_rvalid", 32'(d_rvalid), 32'd1);
    tick();

    // Reset right after a fetch grant: the response is dropped.
    rst_n = 1'b0;
    #4 chk_all_zero("mrst_a");
    tick();
    #4 chk_all_zero("mrst_b");
    tick();
    rst_n = 1'b1;
    #4 chk_all_zero("mrel");
    tick();
    #4;
    chk("mrel.tie_if_gnt", 32'(if_gnt), 32'd1);
    chk("mrel.tie_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    #4;
    chk("mrel.if_rvalid", 32'(if_rvalid), 32'd1);
    chk("mrel.if_rdata", if_rdata, 32'hCAFE0001);
    tick();

    // Randomized traffic against a reference model.
    last_d = 1'b0; exp_pend = 1'b0; exp_own_d = 1'b0; exp_data = '0;
    gi_prev = 1'b0; gd_prev = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      chk("rnd.if_rvalid", 32'(if_rvalid), 32'(exp_pend && !exp_own_d));
      chk("rnd.d_rvalid", 32'(d_rvalid), 32'(exp_pend && exp_own_d));
      if (exp_pend) chk("rnd.rdata", exp_own_d ? d_rdata : if_rdata, exp_data);
      if (!if_req || gi_prev) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 15));
      end
      if (!d_req || gd_prev) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      #4;
      gi = if_req && (!d_req || last_d);
      gd = d_req && (!if_req || !last_d);
      chk("rnd.if_gnt", 32'(if_gnt), 32'(gi));
      chk("rnd.d_gnt", 32'(d_gnt), 32'(gd));
      chk("rnd.rw_excl", 32'(mem_read & mem_write), 32'd0);
      chk("rnd.mem_read", 32'(mem_read), 32'(gi || (gd && !d_we)));
      chk("rnd.mem_write", 32'(mem_write), 32'(gd && d_we));
      if (gi || gd) chk("rnd.mem_addr", mem_addr, gd ? d_addr : if_addr);
      if (gd && d_we) chk("rnd.mem_wdata", mem_wdata, d_wdata);
      exp_pend = gi || (gd && !d_we);
      exp_own_d = gd;
      exp_data = gd ? sh[d_addr[7:0]] : sh[if_addr[7:0]];
      if (gd && d_we) sh[d_addr[7:0]] = d_wdata;
      if (gi || gd) last_d = gd;
      gi_prev = gi; gd_prev = gd;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory word-address width.
REQ-002 Parameter WORD_WIDTH, default 32, memory data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req  input  1  fetch port read request.
REQ-006 if_addr  input  ADDR_WIDTH  fetch read address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  WORD_WIDTH  fetch read data.
REQ-010 d_req  input  1  data port request.
REQ-011 d_we  input  1  data port write (1) / read (0).
REQ-012 d_addr  input  ADDR_WIDTH  data port address.
REQ-013 d_wdata  input  WORD_WIDTH  data port write data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  data read data valid.
REQ-016 d_rdata  output  WORD_WIDTH  data read data.
REQ-017 mem_read, mem_write  output  1 each  memory controls.
REQ-018 mem_addr  output  ADDR_WIDTH; mem_wdata  output  WORD_WIDTH; mem_rdata  input  WORD_WIDTH  memory data out.

Function
REQ-019 The memory shall be a synchronous single-port array with one-cycle read latency: read data appears on mem_rdata the cycle after mem_read is sampled.
REQ-020 At most one requester shall be granted per cycle; grant shall be combinational in the request cycle; a requester holds req/addr/data stable until granted.
REQ-021 One requester only -> that requester granted.
REQ-022 Both requesting -> grant the port not granted most recently (2-way round-robin via a registered last-grant flag, updated only on a grant).
REQ-023 Granted cycle: mem_addr = granted address; fetch grant or data read -> mem_read=1, mem_write=0; data write -> mem_write=1, mem_read=0, mem_wdata=d_wdata.
REQ-024 No grant -> mem_read=0 and mem_write=0; mem_read and mem_write shall never be 1 simultaneously.
REQ-025 Each granted read shall register a pending flag plus owner (IF or D); next cycle exactly the owner's rvalid =1 for one cycle.
REQ-026 if_rdata and d_rdata shall equal mem_rdata; valid only when the matching rvalid is 1.
REQ-027 Writes shall produce no rvalid; write completes at the grant edge.
REQ-028 Back-to-back grants every cycle shall be supported; a read response and a new grant may coincide in the same cycle.
REQ-029 Read-after-write to the same address in consecutive grants shall return the written data.

Reset
REQ-030 While rst_n=0 at posedge: pending flag cleared, last-grant set to D (fetch wins next tie).
REQ-031 During and the cycle after reset: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_read, mem_write shall be 0.
REQ-032 Reset asserted with a read pending shall discard that response; no rvalid after reset release.

Structure
REQ-033 Package mem_arb_pkg shall hold typedef enum owner_e {OWN_IF, OWN_D} and the default ADDR_WIDTH/WORD_WIDTH constants.
REQ-034 The round-robin pick shall be sub-module rr_arb2 (two req in, two one-hot gnt out, last-grant register inside).
REQ-035 Pending flag, owner register and output muxing stay in mem_arbiter.

Verification
REQ-036 Reset, then if_req=1, if_addr=0x10 with mem[0x10]=0xCAFE0001 -> if_gnt same cycle, if_rvalid=1 and if_rdata=0xCAFE0001 next cycle, d_rvalid=0.
REQ-037 d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678, then d read 0x20 -> mem_write one cycle, then d_rvalid with 0x12345678; no rvalid for the write.
REQ-038 if_req and d_req held high for 6 cycles -> grants alternate IF,D,IF,D,IF,D; rvalid owners follow same order one cycle later.
REQ-039 Only d_req high for 4 cycles, then both -> D granted 4 times, then IF wins the tie.
REQ-040 Fetch read granted, rst_n=0 next cycle -> no if_rvalid; all outputs 0; first tie after release grants IF.
REQ-041 Randomized 1000 cycles with scoreboard model -> mem_read&mem_write never both 1, every granted read gets exactly one rvalid to its owner with correct data.
